// File: rtl/psr_ctrl_if.sv
// Control bundle between the pipeline stage logic and the psr_ctrl sequencer.
// The datapath side is the master: it drives requests and hazard/branch status.
interface psr_ctrl_if #(
    parameter int STAGES = 3
);
    logic                run;
    logic                hazard;
    logic                branch_taken;
    logic                halt_req;
    logic [STAGES-1:0]   c_left;
    logic [STAGES-1:0]   c_right;
    logic [STAGES-1:0]   ld_ri;
    logic [STAGES-1:0]   clr_n;
    logic                pc_en;
    logic [STAGES-1:0]   occ;
    logic [7:0]          stall_cnt;
    logic                done;
    logic                err;

    modport master (
        output run, hazard, branch_taken, halt_req,
        input  c_left, c_right, ld_ri, clr_n, pc_en, occ, stall_cnt, done, err
    );

    modport slave (
        input  run, hazard, branch_taken, halt_req,
        output c_left, c_right, ld_ri, clr_n, pc_en, occ, stall_cnt, done, err
    );
endinterface

// File: rtl/psr_ctrl.sv
// Pipeline stage-register sequencer: two-cycle LOAD/SHIFT advances with stall
// bubbles, branch flush, halt/drain and a consecutive-stall watchdog.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after reset, all registers held cleared, waiting for run
// S_LOAD    | load half of an advance; hazard/branch decide the strobes
// S_SHIFT   | shift half of an advance; occupancy moves, halt sampled
// S_DRAIN_L | load half of a drain advance, register 0 fed a bubble
// S_DRAIN_S | shift half of a drain advance
// S_HALTED  | drained, contents preserved, done asserted until run
module psr_ctrl #(
    parameter int STAGES    = 3,
    parameter int BR_STAGE  = 2,
    parameter int MAX_STALL = 15
) (
    input  logic        clk,
    input  logic        rst,
    psr_ctrl_if.slave   bus
);
    localparam int DW = $clog2(STAGES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DRAIN_L,
        S_DRAIN_S,
        S_HALTED
    } state_e;

    state_e              state_q, state_d;
    logic [STAGES-1:0]   occ_q, occ_d;
    logic [7:0]          stall_cnt_q, stall_cnt_d;
    logic                err_q, err_d;
    logic                stall_q, stall_d;
    logic                flush_q, flush_d;
    logic [DW-1:0]       drain_q, drain_d;

    logic [STAGES-1:0]   br_mask;
    logic [STAGES-1:0]   shifted;
    logic [8:0]          stall_inc;
    logic                wd_trip;
    logic [STAGES-1:0]   c_left, c_right, ld_ri, clr_n;
    logic                pc_en;

    always_comb begin
        br_mask = '0;
        for (int k = 0; k < STAGES; k++) begin
            br_mask[k] = (k < BR_STAGE);
        end
    end

    assign shifted   = {occ_q[STAGES-2:0], 1'b0};
    // Unsaturated compare so the watchdog still trips when MAX_STALL is 255.
    assign stall_inc = {1'b0, stall_cnt_q} + 9'd1;
    assign wd_trip   = (stall_inc > 9'(MAX_STALL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            occ_q       <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
            drain_q     <= drain_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        occ_d       = occ_q;
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        drain_d     = drain_q;
        c_left      = '0;
        c_right     = '0;
        ld_ri       = '0;
        clr_n       = '1;
        pc_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                clr_n = '0;
                if (bus.run) begin
                    state_d     = S_LOAD;
                    stall_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT;
                if (bus.branch_taken) begin
                    clr_n       = ~br_mask;
                    c_left      = ~br_mask;
                    flush_d     = 1'b1;
                    stall_d     = 1'b0;
                    stall_cnt_d = '0;
                end else if (bus.hazard) begin
                    // Register 0 keeps its instruction; register 1 takes a bubble.
                    c_left      = '1;
                    c_left[0]   = 1'b0;
                    ld_ri[0]    = 1'b1;
                    clr_n[1]    = 1'b0;
                    flush_d     = 1'b0;
                    stall_d     = 1'b1;
                    stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_inc[7:0];
                    if (wd_trip) begin
                        err_d   = 1'b1;
                        drain_d = '0;
                        state_d = S_DRAIN_L;
                    end
                end else begin
                    c_left      = '1;
                    flush_d     = 1'b0;
                    stall_d     = 1'b0;
                    stall_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                c_right = '1;
                pc_en   = ~stall_q;
                if (flush_q) begin
                    occ_d = shifted & ~br_mask;
                end else if (stall_q) begin
                    occ_d    = shifted;
                    occ_d[0] = occ_q[0];
                    occ_d[1] = 1'b0;
                end else begin
                    occ_d = shifted | STAGES'(1);
                end
                if (bus.halt_req) begin
                    drain_d = '0;
                    state_d = S_DRAIN_L;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DRAIN_L: begin
                clr_n[0]  = 1'b0;
                c_left    = '1;
                c_left[0] = 1'b0;
                state_d   = S_DRAIN_S;
            end
            S_DRAIN_S: begin
                c_right = '1;
                occ_d   = shifted;
                drain_d = drain_q + DW'(1);
                state_d = (drain_q == DW'(STAGES - 1)) ? S_HALTED : S_DRAIN_L;
            end
            S_HALTED: begin
                if (bus.run) begin
                    state_d     = S_LOAD;
                    stall_cnt_d = '0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.c_left    = c_left;
    assign bus.c_right   = c_right;
    assign bus.ld_ri     = ld_ri;
    assign bus.clr_n     = clr_n;
    assign bus.pc_en     = pc_en;
    assign bus.occ       = occ_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.done      = (state_q == S_HALTED);
    assign bus.err       = err_q;
endmodule

// File: tb/tb_psr_ctrl.sv
// Bench for psr_ctrl: directed vector table, async reset corner, then random
// stimulus against a behavioural model of the advance/drain rules.
module tb_psr_ctrl;
    localparam int S   = 3;
    localparam int BR  = 2;
    localparam int MXS = 3;
    localparam int ALL = (1 << S) - 1;
    localparam int BRM = (1 << BR) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    psr_ctrl_if #(.STAGES(S)) bus ();

    psr_ctrl #(.STAGES(S), .BR_STAGE(BR), .MAX_STALL(MXS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          run;
        bit          hz;
        bit          br;
        bit          halt;
        logic [25:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [25:0] pk(int cl, int cr, int ld, int cn, int pc,
                                       int oc, int sc, int dn, int er);
        return {3'(cl), 3'(cr), 3'(ld), 3'(cn), 1'(pc), 3'(oc), 8'(sc), 1'(dn), 1'(er)};
    endfunction

    function automatic logic [25:0] act();
        return {bus.c_left, bus.c_right, bus.ld_ri, bus.clr_n, bus.pc_en,
                bus.occ, bus.stall_cnt, bus.done, bus.err};
    endfunction

    task automatic chk(string nm, logic [25:0] a, logic [25:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic add(bit r, bit h, bit b, bit hl, logic [25:0] e);
        vec_t v;
        v.run = r; v.hz = h; v.br = b; v.halt = hl; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic drive(bit r, bit h, bit b, bit hl);
        bus.run = r; bus.hazard = h; bus.branch_taken = b; bus.halt_req = hl;
    endtask

    // Behavioural model: mode names the half-advance the controller is in.
    typedef enum int {M_IDLE, M_LOAD, M_SHIFT, M_DL, M_DS, M_HALT} mode_e;
    mode_e m_mode;
    int    m_occ, m_sc, m_err, m_last, m_left;

    task automatic m_reset();
        m_mode = M_IDLE; m_occ = 0; m_sc = 0; m_err = 0; m_last = 0; m_left = 0;
    endtask

    function automatic logic [25:0] m_exp(bit hz, bit br);
        int cl = 0, cr = 0, ld = 0, cn = ALL, pc = 0, dn = 0;
        case (m_mode)
            M_IDLE:  cn = 0;
            M_LOAD:  if (br) begin cl = ALL & ~BRM; cn = ALL & ~BRM; end
                     else if (hz) begin cl = ALL - 1; ld = 1; cn = ALL - 2; end
                     else cl = ALL;
            M_SHIFT: begin cr = ALL; pc = (m_last != 1); end
            M_DL:    begin cl = ALL - 1; cn = ALL - 1; end
            M_DS:    cr = ALL;
            default: dn = 1;
        endcase
        return pk(cl, cr, ld, cn, pc, m_occ, m_sc, dn, m_err);
    endfunction

    task automatic m_step(bit run, bit hz, bit br, bit halt);
        case (m_mode)
            M_IDLE, M_HALT: if (run) begin m_mode = M_LOAD; m_sc = 0; m_err = 0; end
            M_LOAD: begin
                m_mode = M_SHIFT;
                if (br) begin m_last = 2; m_sc = 0; end
                else if (hz) begin
                    m_last = 1;
                    if (m_sc < 255) m_sc++;
                    if (m_sc > MXS) begin m_err = 1; m_mode = M_DL; m_left = S; end
                end else begin m_last = 0; m_sc = 0; end
            end
            M_SHIFT: begin
                if (m_last == 2)      m_occ = (m_occ << 1) & ALL & ~BRM;
                else if (m_last == 1) m_occ = ((m_occ << 1) & ALL & ~3) | (m_occ & 1);
                else                  m_occ = ((m_occ << 1) | 1) & ALL;
                if (halt) begin m_mode = M_DL; m_left = S; end
                else m_mode = M_LOAD;
            end
            M_DL: m_mode = M_DS;
            default: begin
                m_occ = (m_occ << 1) & ALL;
                m_left--;
                m_mode = (m_left == 0) ? M_HALT : M_DL;
            end
        endcase
    endtask

    initial begin
        drive(0, 0, 0, 0);
        // Directed sequence: outputs seen before each rising edge.
        add(0,0,0,0, pk(0,0,0,0,0,0,0,0,0));
        add(1,0,0,0, pk(0,0,0,0,0,0,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,0,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,0,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,1,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,1,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,3,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,3,0,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,7,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,0,7,1,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,5,1,0,0));
        add(0,0,0,0, pk(0,7,0,7,0,5,2,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,1,2,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,1,0,0,0));
        add(0,1,1,0, pk(4,0,0,4,0,3,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,3,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,4,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,4,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,1,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,1,0,0,0));
        add(0,0,0,0, pk(7,0,0,7,0,3,0,0,0));
        add(0,0,0,1, pk(0,7,0,7,1,3,0,0,0));
        add(1,1,1,1, pk(6,0,0,6,0,7,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,0,7,0,0,0));
        add(0,0,0,0, pk(6,0,0,6,0,6,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,0,6,0,0,0));
        add(0,0,0,0, pk(6,0,0,6,0,4,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,0,4,0,0,0));
        add(0,0,0,0, pk(0,0,0,7,0,0,0,1,0));
        add(1,0,0,0, pk(0,0,0,7,0,0,0,1,0));
        add(0,0,0,0, pk(7,0,0,7,0,0,0,0,0));
        add(0,0,0,0, pk(0,7,0,7,1,0,0,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,1,0,0,0));
        add(0,1,0,0, pk(0,7,0,7,0,1,1,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,1,1,0,0));
        add(0,1,0,0, pk(0,7,0,7,0,1,2,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,1,2,0,0));
        add(0,1,0,0, pk(0,7,0,7,0,1,3,0,0));
        add(0,1,0,0, pk(6,0,1,5,0,1,3,0,0));
        add(0,1,0,0, pk(6,0,0,6,0,1,4,0,1));
        add(0,1,0,0, pk(0,7,0,7,0,1,4,0,1));
        add(0,1,0,0, pk(6,0,0,6,0,2,4,0,1));
        add(0,1,0,0, pk(0,7,0,7,0,2,4,0,1));
        add(0,1,0,0, pk(6,0,0,6,0,4,4,0,1));
        add(0,1,0,0, pk(0,7,0,7,0,4,4,0,1));
        add(0,1,0,0, pk(0,0,0,7,0,0,4,1,1));
        add(1,0,0,0, pk(0,0,0,7,0,0,4,1,1));
        add(0,0,0,0, pk(7,0,0,7,0,0,0,0,0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].hz, vecs[i].br, vecs[i].halt);
            #1;
            chk($sformatf("vec%0d", i), act(), vecs[i].exp);
            @(negedge clk);
        end

        // Two more clean advances, then an async reset in the middle of SHIFT.
        drive(0, 0, 0, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("pre_rst_shift", act(), pk(0,7,0,7,1,3,0,0,0));
        #1 rst = 1'b1;
        #1;
        chk("async_rst", act(), pk(0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        m_reset();
        begin
            int hz_pct = 30;
            for (int c = 0; c < 4000; c++) begin
                bit r, h, b, hl;
                if (c % 100 == 0) hz_pct = $urandom_range(10, 90);
                r  = ($urandom_range(0, 2) == 0);
                h  = ($urandom_range(0, 99) < hz_pct);
                b  = ($urandom_range(0, 9) == 0);
                hl = ($urandom_range(0, 14) == 0);
                drive(r, h, b, hl);
                #1;
                chk($sformatf("rand%0d", c), act(), m_exp(h, b));
                m_step(r, h, b, hl);
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
